// File: rtl/gal_pkg.sv
// Shared GAL16V8 constants: fuse/payload geometry, frame header bytes,
// loader states and error codes.
package gal_pkg;

   localparam int GAL16V8_FUSES         = 2194;
   localparam int GAL16V8_PAYLOAD_BYTES = (GAL16V8_FUSES + 7) / 8;

   // Header: device id 16V8, then fuse count big-endian
   localparam logic [7:0] HDR_DEV_HI = 8'h16;
   localparam logic [7:0] HDR_DEV_LO = 8'h08;
   localparam logic [7:0] HDR_CNT_HI = 8'(GAL16V8_FUSES >> 8);
   localparam logic [7:0] HDR_CNT_LO = 8'(GAL16V8_FUSES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_CKSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_HDR   = 2'd1;
   localparam logic [1:0] ERR_PAD   = 2'd2;
   localparam logic [1:0] ERR_CKSUM = 2'd3;

   function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] count);
      case (idx)
         2'd0:    hdr_byte = HDR_DEV_HI;
         2'd1:    hdr_byte = HDR_DEV_LO;
         2'd2:    hdr_byte = count[15:8];
         default: hdr_byte = count[7:0];
      endcase
   endfunction

endpackage

// File: rtl/gal_cksum16.sv
// Running 16-bit byte sum (mod 2^16) over the fuse payload.
module gal_cksum16
   import gal_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        add_en,
   input  logic [7:0]  byte_in,
   output logic [15:0] sum
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum <= '0;
      else if (clear)
         sum <= '0;
      else if (add_en)
         sum <= sum + {8'h00, byte_in};
   end

endmodule

// File: rtl/gal16v8_fuse_loader.sv
// Byte-stream fuse image loader: checks header, pad bits and checksum, and
// commits the shadow map to fuses only when the whole frame is good.
module gal16v8_fuse_loader
   import gal_pkg::*;
#(
   parameter int FUSE_COUNT    = GAL16V8_FUSES,
   parameter int PAYLOAD_BYTES = GAL16V8_PAYLOAD_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [FUSE_COUNT-1:0] fuses,
   output logic                  fuses_valid,
   output logic                  busy,
   output logic                  error,
   output logic [1:0]            err_code
);

   localparam int          IW        = $clog2(FUSE_COUNT);
   localparam logic [8:0]  LAST_IDX  = 9'(PAYLOAD_BYTES - 1);
   localparam int          LAST_BITS = FUSE_COUNT - 8 * (PAYLOAD_BYTES - 1);
   localparam logic [7:0]  PAD_MASK  = 8'(8'hFF << LAST_BITS);
   localparam logic [15:0] FC16      = 16'(FUSE_COUNT);

   state_t                state;
   logic [8:0]            cnt;
   logic [7:0]            cksum_hi;
   logic [15:0]           sum;
   logic [FUSE_COUNT-1:0] shadow;
   logic                  accept;

   assign in_ready = !start && (state == S_HDR || state == S_PAYLOAD || state == S_CKSUM);
   assign accept   = in_valid && in_ready;

   gal_cksum16 u_cksum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start),
      .add_en  (accept && state == S_PAYLOAD),
      .byte_in (in_data),
      .sum     (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         cksum_hi    <= '0;
         shadow      <= '0;
         fuses       <= '0;
         fuses_valid <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
      end else if (start) begin
         state    <= S_HDR;
         cnt      <= '0;
         busy     <= 1'b1;
         error    <= 1'b0;
         err_code <= ERR_NONE;
      end else if (accept) begin
         case (state)
            S_HDR: begin
               if (in_data != hdr_byte(cnt[1:0], FC16)) begin
                  state    <= S_ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_HDR;
               end else if (cnt == 9'd3) begin
                  state <= S_PAYLOAD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            S_PAYLOAD: begin
               // Pad bits of the last byte have no home in the map
               for (int j = 0; j < 8; j++)
                  if (int'(cnt) * 8 + j < FUSE_COUNT)
                     shadow[IW'(int'(cnt) * 8 + j)] <= in_data[j];
               if (cnt == LAST_IDX) begin
                  cnt <= '0;
                  if ((in_data & PAD_MASK) != 8'h00) begin
                     state    <= S_ERROR;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                     err_code <= ERR_PAD;
                  end else begin
                     state <= S_CKSUM;
                  end
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            S_CKSUM: begin
               if (cnt == 9'd0) begin
                  cksum_hi <= in_data;
                  cnt      <= 9'd1;
               end else if ({cksum_hi, in_data} == sum) begin
                  state       <= S_DONE;
                  busy        <= 1'b0;
                  fuses       <= shadow;
                  fuses_valid <= 1'b1;
               end else begin
                  state    <= S_ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_CKSUM;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gal16v8_fuse_loader.sv
// Randomized self-checking bench for gal16v8_fuse_loader against a frame-level
// reference model (header/pad/checksum rules applied to whole byte frames).
module tb_gal16v8_fuse_loader;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2193:0] fuses;
   logic          fuses_valid;
   logic          busy;
   logic          error;
   logic [1:0]    err_code;

   int            checks = 0;
   int            errors = 0;
   logic [2193:0] ref_fuses = '0;
   logic          ref_valid = 1'b0;

   always #5 clk = ~clk;

   gal16v8_fuse_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .fuses       (fuses),
      .fuses_valid (fuses_valid),
      .busy        (busy),
      .error       (error),
      .err_code    (err_code)
   );

   // ---------------- reference model ----------------
   function automatic bq_t make_frame(input bq_t p, input int lo_delta);
      bq_t f;
      int  sum = 0;
      f = '{8'h16, 8'h08, 8'h08, 8'h92};
      foreach (p[i]) begin
         f.push_back(p[i]);
         sum += int'(p[i]);
      end
      sum = sum % 65536;
      f.push_back(8'(sum / 256));
      f.push_back(8'(sum % 256 + lo_delta));
      return f;
   endfunction

   function automatic void model(input bq_t f, output logic [1:0] code, output int nacc);
      logic [7:0] hdr [4];
      int         sum = 0;
      hdr = '{8'h16, 8'h08, 8'h08, 8'h92};
      for (int i = 0; i < 4; i++)
         if (f[i] != hdr[i]) begin
            code = 2'd1; nacc = i + 1; return;
         end
      if (f[278] > 8'h03) begin
         code = 2'd2; nacc = 279; return;
      end
      for (int i = 4; i < 279; i++) sum += int'(f[i]);
      nacc = 281;
      code = ((sum % 65536) == int'(f[279]) * 256 + int'(f[280])) ? 2'd0 : 2'd3;
   endfunction

   function automatic logic [2193:0] image(input bq_t f);
      logic [2193:0] img;
      for (int i = 0; i < 2194; i++) img[i] = f[4 + i / 8][i % 8];
      return img;
   endfunction

   function automatic bq_t rand_payload();
      bq_t p;
      for (int i = 0; i < 275; i++) p.push_back(8'($urandom_range(255)));
      p[274] = p[274] & 8'h03;
      return p;
   endfunction

   // Updates the expected committed image after a frame; returns expected code/accepts
   task automatic predict(input bq_t f, output logic [1:0] code, output int nacc);
      model(f, code, nacc);
      if (code == 2'd0) begin
         ref_fuses = image(f);
         ref_valid = 1'b1;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input bq_t f, input int gap, input bit do_start, output int acc);
      int   cyc = 0;
      logic rdy, v;
      acc = 0;
      if (do_start) pulse_start();
      while (acc < f.size()) begin
         in_data  = f[acc];
         in_valid = ($urandom_range(99) >= gap);
         #1;
         if (!busy) break;
         rdy = in_ready;
         v   = in_valid;
         @(posedge clk);
         if (v && rdy) acc++;
         @(negedge clk);
         cyc++;
         if (cyc > 4000) begin
            checks++; errors++;
            $display("FAIL frame_timeout accepted=%0d", acc);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fuses !== '0) begin errors++; $display("FAIL reset_fuses ones=%0d want 0", $countones(fuses)); end
      checks++; if (fuses_valid !== 1'b0) begin errors++; $display("FAIL reset_fuses_valid got %b want 0", fuses_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", err_code); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
   endtask

   function automatic bq_t plan_payload();
      bq_t p;
      for (int i = 0; i < 275; i++) p.push_back(8'(i < 256 ? i : i - 256));
      p[274] = 8'h03;
      return p;
   endfunction

   task automatic test_good_frame(input int gap);
      bq_t        f;
      logic [1:0] code;
      int         nacc, acc;
      f = make_frame(plan_payload(), 0);
      predict(f, code, nacc);
      run_frame(f, gap, 1'b1, acc);
      checks++; if (acc !== nacc) begin errors++; $display("FAIL good_accepts gap=%0d got %0d want %0d", gap, acc, nacc); end
      checks++; if (err_code !== code) begin errors++; $display("FAIL good_err_code got %0d want %0d", err_code, code); end
      checks++; if (fuses_valid !== 1'b1) begin errors++; $display("FAIL good_fuses_valid got %b want 1", fuses_valid); end
      checks++; if (fuses !== ref_fuses) begin errors++; $display("FAIL good_fuses diffbits=%0d want 0", $countones(fuses ^ ref_fuses)); end
      checks++; if (fuses[7:0] !== 8'h00 || fuses[2055:2048] !== 8'h00 || fuses[2193:2192] !== 2'b11)
         begin errors++; $display("FAIL good_fuse_fields got %h %h %b want 00 00 11", fuses[7:0], fuses[2055:2048], fuses[2193:2192]); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || error !== 1'b0)
         begin errors++; $display("FAIL good_done_flags busy=%b in_ready=%b error=%b want 0 0 0", busy, in_ready, error); end
   endtask

   task automatic test_hdr_error();
      bq_t        f;
      logic [1:0] code;
      int         nacc, acc;
      f = make_frame(rand_payload(), 0);
      f[1] = 8'h0A;
      predict(f, code, nacc);
      run_frame(f, 0, 1'b1, acc);
      checks++; if (acc !== 2) begin errors++; $display("FAIL hdr_accepts got %0d want 2", acc); end
      checks++; if (err_code !== 2'd1 || error !== 1'b1) begin errors++; $display("FAIL hdr_err_code got %0d/%b want 1/1", err_code, error); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hdr_in_ready got %b want 0", in_ready); end
      checks++; if (fuses !== ref_fuses || fuses_valid !== ref_valid)
         begin errors++; $display("FAIL hdr_prior_fuses diffbits=%0d valid=%b want 0 %b", $countones(fuses ^ ref_fuses), fuses_valid, ref_valid); end
   endtask

   task automatic test_pad_error();
      bq_t        f, p;
      logic [1:0] code;
      int         nacc, acc;
      p = rand_payload();
      p[274] = 8'h07;
      f = make_frame(p, 0);
      predict(f, code, nacc);
      run_frame(f, 0, 1'b1, acc);
      checks++; if (acc !== nacc) begin errors++; $display("FAIL pad_accepts got %0d want %0d", acc, nacc); end
      checks++; if (err_code !== 2'd2 || error !== 1'b1) begin errors++; $display("FAIL pad_err_code got %0d/%b want 2/1", err_code, error); end
      checks++; if (fuses !== ref_fuses || fuses_valid !== ref_valid)
         begin errors++; $display("FAIL pad_prior_fuses diffbits=%0d valid=%b", $countones(fuses ^ ref_fuses), fuses_valid); end
   endtask

   task automatic test_cksum_error();
      bq_t        f;
      logic [1:0] code;
      int         nacc, acc;
      f = make_frame(rand_payload(), 1);
      predict(f, code, nacc);
      run_frame(f, 0, 1'b1, acc);
      checks++; if (acc !== 281) begin errors++; $display("FAIL cksum_accepts got %0d want 281", acc); end
      checks++; if (err_code !== 2'd3 || error !== 1'b1) begin errors++; $display("FAIL cksum_err_code got %0d/%b want 3/1", err_code, error); end
      checks++; if (fuses !== ref_fuses || fuses_valid !== 1'b1)
         begin errors++; $display("FAIL cksum_prior_fuses diffbits=%0d valid=%b want 0 1", $countones(fuses ^ ref_fuses), fuses_valid); end
   endtask

   task automatic test_random_gaps();
      bq_t        f, p;
      logic [1:0] code;
      int         nacc, acc, kind;
      for (int n = 0; n < 5; n++) begin
         p    = rand_payload();
         kind = (n == 0) ? 0 : int'($urandom_range(3));
         if (kind == 1) p[274] = p[274] | 8'(4 << $urandom_range(5));
         f = make_frame(p, (kind == 2) ? int'($urandom_range(1, 255)) : 0);
         if (kind == 3) f[$urandom_range(3)] ^= 8'(1 << $urandom_range(7));
         predict(f, code, nacc);
         run_frame(f, 50, 1'b1, acc);
         checks++; if (acc !== nacc) begin errors++; $display("FAIL gap_accepts n=%0d got %0d want %0d", n, acc, nacc); end
         checks++; if (err_code !== code || error !== (code != 2'd0))
            begin errors++; $display("FAIL gap_err_code n=%0d got %0d/%b want %0d", n, err_code, error, code); end
         checks++; if (fuses !== ref_fuses || fuses_valid !== ref_valid)
            begin errors++; $display("FAIL gap_fuses n=%0d diffbits=%0d valid=%b", n, $countones(fuses ^ ref_fuses), fuses_valid); end
      end
   endtask

   task automatic test_restart();
      bq_t        fa, fb;
      logic [1:0] code;
      int         nacc, acc;
      fa = make_frame(rand_payload(), 0);
      fb = make_frame(rand_payload(), 0);
      run_frame(fa[0:103], 0, 1'b1, acc);
      // start coincides with a valid byte that would pass as header byte 0
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h16;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL restart_in_ready got %b want 0", in_ready); end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL restart_busy got %b/%b want 1/0", busy, error); end
      predict(fb, code, nacc);
      run_frame(fb, 25, 1'b0, acc);
      checks++; if (acc !== 281 || err_code !== 2'd0) begin errors++; $display("FAIL restart_load accepts=%0d code=%0d want 281 0", acc, err_code); end
      checks++; if (fuses !== ref_fuses || fuses_valid !== 1'b1)
         begin errors++; $display("FAIL restart_fuses diffbits=%0d valid=%b", $countones(fuses ^ ref_fuses), fuses_valid); end
   endtask

   task automatic test_mid_reset();
      bq_t f;
      int  acc;
      f = make_frame(rand_payload(), 0);
      run_frame(f[0:149], 0, 1'b1, acc);
      rst_n = 1'b0;
      #1;
      checks++; if (fuses !== '0 || fuses_valid !== 1'b0)
         begin errors++; $display("FAIL midrst_fuses ones=%0d valid=%b want 0 0", $countones(fuses), fuses_valid); end
      checks++; if (busy !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b0)
         begin errors++; $display("FAIL midrst_flags busy=%b error=%b code=%0d in_ready=%b want 0", busy, error, err_code, in_ready); end
      ref_fuses = '0;
      ref_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_good_frame(0);
      test_hdr_error();
      test_pad_error();
      test_cksum_error();
      test_good_frame(50);
      test_random_gaps();
      test_restart();
      test_mid_reset();
      test_good_frame(0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
